// File: rtl/pipe_hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl_if
// Bundle of pipeline observation inputs and hold/bubble control outputs that
// run between the five-stage pipeline and the hazard sequencer.
//   slave  : the hazard controller (observes ID/EX/MEM, drives controls)
//   master : the pipeline / data memory side (drives observations)
// Signals:
//   id_rs1/id_rs2 (5), id_rs1_used/id_rs2_used : ID source operands
//   idex_regD (5), idex_is_load                 : instruction in EX
//   ex_branch_taken                             : branch in EX resolved taken
//   exmem_mem_op, dmem_ready, dmem_req          : MEM access handshake
//   pc_stall, ifid_stall, idex_stall, exmem_stall : hold controls
//   ifid_flush, idex_flush, memwb_bubble        : bubble controls
//   mem_err                                     : sticky memory timeout
// ---------------------------------------------------------------------------
interface pipe_hazard_if;
   logic [4:0] id_rs1;
   logic [4:0] id_rs2;
   logic       id_rs1_used;
   logic       id_rs2_used;
   logic [4:0] idex_regD;
   logic       idex_is_load;
   logic       ex_branch_taken;
   logic       exmem_mem_op;
   logic       dmem_ready;
   logic       dmem_req;
   logic       pc_stall;
   logic       ifid_stall;
   logic       idex_stall;
   logic       exmem_stall;
   logic       ifid_flush;
   logic       idex_flush;
   logic       memwb_bubble;
   logic       mem_err;

   modport slave (
      input  id_rs1, id_rs2, id_rs1_used, id_rs2_used, idex_regD, idex_is_load,
             ex_branch_taken, exmem_mem_op, dmem_ready,
      output dmem_req, pc_stall, ifid_stall, idex_stall, exmem_stall,
             ifid_flush, idex_flush, memwb_bubble, mem_err
   );

   modport master (
      output id_rs1, id_rs2, id_rs1_used, id_rs2_used, idex_regD, idex_is_load,
             ex_branch_taken, exmem_mem_op, dmem_ready,
      input  dmem_req, pc_stall, ifid_stall, idex_stall, exmem_stall,
             ifid_flush, idex_flush, memwb_bubble, mem_err
   );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
// Stall/flush sequencer for the five-stage integer pipeline: load-use
// interlock, taken-branch wrong-path kill, and multi-cycle data memory
// accesses with a timeout into a sticky error state.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   hz          : pipe_hazard_if.slave (observations in, controls out)
//   stall_cycles, kill_count (CNT_WIDTH) : performance counters, present
//                 only when the PIPE_CTRL_PERF_EN macro is defined
// Parameters:
//   MEM_TIMEOUT : MEM_WAIT cycles without dmem_ready before MEM_ERR (1..1023)
//   CNT_WIDTH   : performance counter width
// All controls are combinational from state and inputs, forced to 0 while
// reset is high.
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl #(
   parameter int MEM_TIMEOUT = 255,
   parameter int CNT_WIDTH   = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   pipe_hazard_if.slave         hz
`ifdef PIPE_CTRL_PERF_EN
   ,
   output logic [CNT_WIDTH-1:0] stall_cycles,
   output logic [CNT_WIDTH-1:0] kill_count
`endif
);

   typedef enum logic [1:0] {RUN, MEM_WAIT, MEM_ERR} state_t;

   localparam logic [9:0] TIMEOUT = 10'(MEM_TIMEOUT);

   state_t     r_state, w_state_nxt;
   logic [9:0] r_wait_cnt, w_wait_nxt;
   logic       r_kill_pending, w_kill_nxt;

   logic w_load_use;
   logic w_req, w_pc_s, w_ifid_s, w_idex_s, w_exmem_s;
   logic w_ifid_f, w_idex_f, w_mwb, w_err;

   // Register 0 is hard-wired, so a load into x0 never creates a hazard.
   assign w_load_use = hz.idex_is_load && (hz.idex_regD != 5'd0) &&
                       ((hz.id_rs1_used && (hz.id_rs1 == hz.idex_regD)) ||
                        (hz.id_rs2_used && (hz.id_rs2 == hz.idex_regD)));

   always_comb begin
      w_state_nxt = r_state;
      w_wait_nxt  = r_wait_cnt;
      w_kill_nxt  = r_kill_pending;
      w_req       = 1'b0;
      w_pc_s      = 1'b0;
      w_ifid_s    = 1'b0;
      w_idex_s    = 1'b0;
      w_exmem_s   = 1'b0;
      w_ifid_f    = 1'b0;
      w_idex_f    = 1'b0;
      w_mwb       = 1'b0;
      w_err       = 1'b0;
      if (!reset) begin
         case (r_state)
            RUN: begin
               w_req = hz.exmem_mem_op;
               if (hz.exmem_mem_op && !hz.dmem_ready) begin
                  // Branch/load-use are ignored: everything is frozen and
                  // gets re-evaluated once the access completes.
                  {w_pc_s, w_ifid_s, w_idex_s, w_exmem_s, w_mwb} = '1;
                  w_state_nxt = MEM_WAIT;
                  w_wait_nxt  = 10'd1;
               end else if (w_load_use) begin
                  w_pc_s   = 1'b1;
                  w_ifid_s = 1'b1;
                  w_idex_f = 1'b1;
                  // Delay slot is held this cycle; the wrong-path kill is
                  // deferred to the next free cycle.
                  if (hz.ex_branch_taken) w_kill_nxt = 1'b1;
               end else if (hz.ex_branch_taken || r_kill_pending) begin
                  w_ifid_f   = 1'b1;
                  w_kill_nxt = 1'b0;
               end
            end
            MEM_WAIT: begin
               w_req = 1'b1;
               // The ready cycle lets MEM retire, so it is not stalled;
               // otherwise the held access would be re-requested in RUN.
               if (hz.dmem_ready) begin
                  w_state_nxt = RUN;
                  w_wait_nxt  = 10'd0;
               end else begin
                  {w_pc_s, w_ifid_s, w_idex_s, w_exmem_s, w_mwb} = '1;
                  if (r_wait_cnt == TIMEOUT)
                     w_state_nxt = MEM_ERR;
                  else if (r_wait_cnt != 10'h3FF)
                     w_wait_nxt = r_wait_cnt + 10'd1;
               end
            end
            MEM_ERR: begin
               {w_pc_s, w_ifid_s, w_idex_s, w_exmem_s} = '1;
               {w_ifid_f, w_idex_f, w_mwb, w_err}      = '1;
            end
            default: w_state_nxt = RUN;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state        <= RUN;
         r_wait_cnt     <= 10'd0;
         r_kill_pending <= 1'b0;
      end else begin
         r_state        <= w_state_nxt;
         r_wait_cnt     <= w_wait_nxt;
         r_kill_pending <= w_kill_nxt;
      end
   end

   assign hz.dmem_req     = w_req;
   assign hz.pc_stall     = w_pc_s;
   assign hz.ifid_stall   = w_ifid_s;
   assign hz.idex_stall   = w_idex_s;
   assign hz.exmem_stall  = w_exmem_s;
   assign hz.ifid_flush   = w_ifid_f;
   assign hz.idex_flush   = w_idex_f;
   assign hz.memwb_bubble = w_mwb;
   assign hz.mem_err      = w_err;

`ifdef PIPE_CTRL_PERF_EN
   logic [CNT_WIDTH-1:0] r_stall_cycles, r_kill_count;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_stall_cycles <= '0;
         r_kill_count   <= '0;
      end else begin
         if (w_pc_s)
            r_stall_cycles <= r_stall_cycles + CNT_WIDTH'(1);
         if (w_ifid_f && (r_state == RUN))
            r_kill_count <= r_kill_count + CNT_WIDTH'(1);
      end
   end

   assign stall_cycles = r_stall_cycles;
   assign kill_count   = r_kill_count;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;
   // Output vector bit positions:
   // {dmem_req, pc_s, ifid_s, idex_s, exmem_s, ifid_f, idex_f, memwb_b, mem_err}
   localparam logic [8:0] O_REQ = 9'h100, O_PC = 9'h080, O_IFS = 9'h040,
                          O_IDS = 9'h020, O_EXS = 9'h010, O_IFF = 9'h008,
                          O_IDF = 9'h004, O_MWB = 9'h002, O_ERR = 9'h001;
   localparam logic [8:0] LU  = O_PC | O_IFS | O_IDF;
   localparam logic [8:0] MS  = O_REQ | O_PC | O_IFS | O_IDS | O_EXS | O_MWB;
   localparam logic [8:0] ERR = O_PC | O_IFS | O_IDS | O_EXS | O_IFF | O_IDF |
                                O_MWB | O_ERR;

   logic clk, reset;
   pipe_hazard_if hz();

`ifdef PIPE_CTRL_PERF_EN
   logic [3:0] stall_cycles, kill_count;
`endif

   pipe_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_WIDTH(4)) dut (
      .clk   (clk),
      .reset (reset),
      .hz    (hz)
`ifdef PIPE_CTRL_PERF_EN
      ,
      .stall_cycles (stall_cycles),
      .kill_count   (kill_count)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int n_cmp  = 0;
   int n_fail = 0;

   typedef struct {
      string      name;
      logic [4:0] rs1, rs2, rd;
      logic       u1, u2, ld, br, mop, rdy;
      logic [8:0] exp;
   } vec_t;

   vec_t vecs[10];

   function automatic logic [8:0] outs();
      return {hz.dmem_req, hz.pc_stall, hz.ifid_stall, hz.idex_stall,
              hz.exmem_stall, hz.ifid_flush, hz.idex_flush, hz.memwb_bubble,
              hz.mem_err};
   endfunction

   task automatic drive(input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic u1, input logic u2, input logic [4:0] rd,
                        input logic ld, input logic br, input logic mop,
                        input logic rdy);
      hz.id_rs1 = rs1; hz.id_rs2 = rs2;
      hz.id_rs1_used = u1; hz.id_rs2_used = u2;
      hz.idex_regD = rd; hz.idex_is_load = ld;
      hz.ex_branch_taken = br; hz.exmem_mem_op = mop; hz.dmem_ready = rdy;
   endtask

   task automatic idle();
      drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   // Compare at the falling edge, then let the rising edge commit state.
   task automatic tick_chk(input string nm, input logic [8:0] exp);
      @(negedge clk);
      n_cmp++;
      if (outs() !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, outs(), exp);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic chk_val(input string nm, input int got, input int exp);
      n_cmp++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, got, exp);
      end
   endtask

   initial begin
      //          name          rs1 rs2 rd  u1 u2 ld br mop rdy exp
      vecs[0] = '{"lu_rs1",     5,  0,  5,  1, 0, 1, 0, 0,  0,  LU};
      vecs[1] = '{"lu_unused",  5,  0,  5,  0, 0, 1, 0, 0,  0,  9'h0};
      vecs[2] = '{"lu_x0",      0,  0,  0,  1, 1, 1, 0, 0,  0,  9'h0};
      vecs[3] = '{"noload",     5,  5,  5,  1, 1, 0, 0, 0,  0,  9'h0};
      vecs[4] = '{"lu_rs2",     3,  7,  7,  1, 1, 1, 0, 0,  0,  LU};
      vecs[5] = '{"lu_rs2_off", 3,  7,  7,  1, 0, 1, 0, 0,  0,  9'h0};
      vecs[6] = '{"br_alone",   0,  0,  0,  0, 0, 0, 1, 0,  0,  O_IFF};
      vecs[7] = '{"mem_ready",  0,  0,  0,  0, 0, 0, 0, 1,  1,  O_REQ};
      vecs[8] = '{"mem_rdy_lu", 9,  0,  9,  1, 0, 1, 0, 1,  1,  O_REQ | LU};
      vecs[9] = '{"mem_rdy_br", 0,  0,  0,  0, 0, 0, 1, 1,  1,  O_REQ | O_IFF};

      // Reset cycle: controls silent even with hazards present.
      reset = 1'b1;
      drive(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0);
      tick_chk("reset_outs", 9'h0);
      reset = 1'b0;
      idle();
      tick_chk("post_reset", 9'h0);

      foreach (vecs[i]) begin
         drive(vecs[i].rs1, vecs[i].rs2, vecs[i].u1, vecs[i].u2, vecs[i].rd,
               vecs[i].ld, vecs[i].br, vecs[i].mop, vecs[i].rdy);
         tick_chk(vecs[i].name, vecs[i].exp);
      end

      // Load-use lasts one cycle: the bubble clears idex_is_load.
      drive(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
      tick_chk("lu_cycle", LU);
      drive(5'd5, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      tick_chk("lu_release", 9'h0);

      // Branch with simultaneous load-use: stall first, kill deferred.
      drive(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
      tick_chk("br_lu_stall", LU);
      idle();
      tick_chk("br_lu_kill", O_IFF);
      tick_chk("br_lu_done", 9'h0);

      // Store waiting 3 cycles; branch during the wait is ignored.
      drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      tick_chk("mw_run_stall", MS);
      hz.ex_branch_taken = 1'b1;
      tick_chk("mw_wait1_br", MS);
      hz.ex_branch_taken = 1'b0;
      tick_chk("mw_wait2", MS);
      hz.dmem_ready = 1'b1;
      tick_chk("mw_ready", O_REQ);
      idle();
      tick_chk("mw_after", 9'h0);

      // Reset while in MEM_WAIT with wait_cnt=2.
      drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      tick_chk("rw_stall", MS);
      tick_chk("rw_wait1", MS);
      reset = 1'b1;
      tick_chk("rw_reset", 9'h0);
      reset = 1'b0;
      hz.dmem_ready = 1'b1;
      tick_chk("rw_run_req", O_REQ);
      idle();
      tick_chk("rw_idle", 9'h0);

      // Timeout: RUN stall, then 4 wait cycles, then MEM_ERR.
      drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
      tick_chk("to_run", MS);
      for (int k = 1; k <= 4; k++) tick_chk($sformatf("to_wait%0d", k), MS);
      tick_chk("to_err", ERR);
      drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      tick_chk("to_err_sticky", ERR);
      reset = 1'b1;
      tick_chk("to_reset", 9'h0);
      reset = 1'b0;
      tick_chk("to_run_idle", 9'h0);
      hz.exmem_mem_op = 1'b1;
      tick_chk("to_run_req", O_REQ);

`ifdef PIPE_CTRL_PERF_EN
      reset = 1'b1;
      idle();
      tick_chk("perf_reset", 9'h0);
      reset = 1'b0;
      chk_val("perf_stall_clr", int'(stall_cycles), 0);
      drive(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 17; k++) tick_chk("perf_lu", LU);
      idle();
      #1;
      chk_val("perf_stall_wrap", int'(stall_cycles), 1);
      chk_val("perf_kill_zero", int'(kill_count), 0);
      hz.ex_branch_taken = 1'b1;
      tick_chk("perf_br", O_IFF);
      idle();
      chk_val("perf_kill_one", int'(kill_count), 1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
